ode_scheduler: RTL and testbench

ODE_SCHEDULER -- requirements
Module: ode_scheduler

---
 rtl/ode_pkg.sv | 23 ++
 rtl/ode_scheduler_ch_pick.sv | 28 ++
 rtl/ode_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_ode_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ode_pkg.sv
// Shared definitions for the ODE channel scheduler.
// State encodings and channel-index width derivation.
package ode_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_INTERP = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;

  function automatic int ode_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int NUM_CH_DEF = 4;
  localparam int CW_DEF     = ode_clog2(NUM_CH_DEF);

endpackage

// File: rtl/ode_scheduler_ch_pick.sv
// Next-set-bit finder over the channel mask.
// wrap_i=1 returns the lowest set bit, else the lowest above cur_i.
module ch_pick
  import ode_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = 2
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CW-1:0]     cur_i,
  input  logic              wrap_i,
  output logic [CW-1:0]     idx_o,
  output logic              found_o
);

  // Scan downward so the last hit is the lowest qualifying bit
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (wrap_i || (i > int'(cur_i)))) begin
        idx_o   = CW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ode_scheduler.sv
// Time-multiplexes one ODE engine and one RAM across channels.
// Engine addresses are prefixed with the active channel index.
module ode_scheduler
  import ode_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 13,
  parameter int NUM_CH        = 4,
  parameter int CW            = ode_clog2(NUM_CH),
  parameter int LW            = ADDRESS_WIDTH - CW
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     INT,
  input  logic                     PROCESS,
  input  logic                     ABORT,
  input  logic                     MODE,
  input  logic [NUM_CH-1:0]        CH_MASK,
  output logic                     DONE,
  output logic                     BUSY,
  output logic [NUM_CH-1:0]        CH_DONE,
  output logic [CW-1:0]            ACTIVE_CH,
  output logic [15:0]              PASS_CNT,
  output logic                     ENG_START,
  input  logic                     ENG_DONE,
  input  logic                     ENG_INTERP_EN,
  output logic                     ENG_INTERP_DONE,
  output logic                     Interpolate_Enable,
  input  logic                     Interpolate_DONE,
  input  logic [LW-1:0]            ENG_ADD_RD1,
  input  logic [LW-1:0]            ENG_ADD_RD2,
  input  logic [LW-1:0]            ENG_ADD_WR,
  input  logic                     ENG_WR_EN,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD1,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD2,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_WR,
  output logic                     RAM_ENABLE_WR
);

  logic [2:0]        state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] ch_done_q, ch_done_d;
  logic [CW-1:0]     active_q, active_d;
  logic [15:0]       pass_q, pass_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              eid_q, eid_d;
  logic              ie_q, ie_d;

  logic [NUM_CH-1:0] lo_mask;
  logic [CW-1:0]     lo_idx, nx_idx;
  logic              lo_found, nx_found;

  // In IDLE the lowest channel comes from the live mask input
  assign lo_mask = (state_q == S_IDLE) ? CH_MASK : mask_q;

  ch_pick #(.NUM_CH(NUM_CH), .CW(CW)) u_pick_lo (
    .mask_i  (lo_mask),
    .cur_i   (active_q),
    .wrap_i  (1'b1),
    .idx_o   (lo_idx),
    .found_o (lo_found)
  );

  ch_pick #(.NUM_CH(NUM_CH), .CW(CW)) u_pick_nx (
    .mask_i  (mask_q),
    .cur_i   (active_q),
    .wrap_i  (1'b0),
    .idx_o   (nx_idx),
    .found_o (nx_found)
  );

  // Scheduler next-state; ABORT outranks every other event
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ch_done_d = ch_done_q;
    active_d  = active_q;
    pass_d    = pass_q;
    pend_d    = pend_q;
    done_d    = done_q;
    ie_d      = ie_q;
    start_d   = 1'b0;
    eid_d     = 1'b0;
    if ((state_q != S_IDLE) && ABORT) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      ie_d    = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (INT && PROCESS) begin
            mask_d    = CH_MASK;
            ch_done_d = '0;
            if (lo_found) begin
              active_d = lo_idx;
              done_d   = 1'b0;
              start_d  = 1'b1;
              state_d  = S_START;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_START: state_d = S_RUN;
        S_RUN: begin
          if (ENG_INTERP_EN) begin
            ie_d    = 1'b1;
            pend_d  = ENG_DONE;
            state_d = S_INTERP;
          end else if (ENG_DONE) begin
            ch_done_d[active_q] = 1'b1;
            state_d = S_NEXT;
          end
        end
        S_INTERP: begin
          if (Interpolate_DONE) begin
            ie_d  = 1'b0;
            eid_d = 1'b1;
            if (pend_q) begin
              pend_d = 1'b0;
              ch_done_d[active_q] = 1'b1;
              state_d = S_NEXT;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_NEXT: begin
          if (nx_found) begin
            active_d = nx_idx;
            start_d  = 1'b1;
            state_d  = S_START;
          end else begin
            pass_d = pass_q + 16'd1;
            if (MODE) begin
              ch_done_d = '0;
              active_d  = lo_idx;
              start_d   = 1'b1;
              state_d   = S_START;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      ch_done_q <= '0;
      active_q  <= '0;
      pass_q    <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      eid_q     <= 1'b0;
      ie_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ch_done_q <= ch_done_d;
      active_q  <= active_d;
      pass_q    <= pass_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      eid_q     <= eid_d;
      ie_q      <= ie_d;
    end
  end

  assign DONE               = done_q;
  assign BUSY               = busy_q;
  assign CH_DONE            = ch_done_q;
  assign ACTIVE_CH          = active_q;
  assign PASS_CNT           = pass_q;
  assign ENG_START          = start_q;
  assign ENG_INTERP_DONE    = eid_q;
  assign Interpolate_Enable = ie_q;

  assign RAM_ADD_RD1   = {active_q, ENG_ADD_RD1};
  assign RAM_ADD_RD2   = {active_q, ENG_ADD_RD2};
  assign RAM_ADD_WR    = {active_q, ENG_ADD_WR};
  assign RAM_ENABLE_WR = ENG_WR_EN &&
                         ((state_q == S_RUN) || (state_q == S_INTERP));

endmodule

// File: tb/tb_ode_scheduler.sv
// Directed self-checking bench for ode_scheduler.
// Inputs change 1ns after a rising edge; outputs checked there too.
module tb_ode_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        INT = 1'b0;
  logic        PROCESS = 1'b0;
  logic        ABORT = 1'b0;
  logic        MODE = 1'b0;
  logic [3:0]  CH_MASK = '0;
  logic        DONE, BUSY;
  logic [3:0]  CH_DONE;
  logic [1:0]  ACTIVE_CH;
  logic [15:0] PASS_CNT;
  logic        ENG_START;
  logic        ENG_DONE = 1'b0;
  logic        ENG_INTERP_EN = 1'b0;
  logic        ENG_INTERP_DONE;
  logic        Interpolate_Enable;
  logic        Interpolate_DONE = 1'b0;
  logic [10:0] ENG_ADD_RD1 = '0;
  logic [10:0] ENG_ADD_RD2 = '0;
  logic [10:0] ENG_ADD_WR = '0;
  logic        ENG_WR_EN = 1'b0;
  logic [12:0] RAM_ADD_RD1, RAM_ADD_RD2, RAM_ADD_WR;
  logic        RAM_ENABLE_WR;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int eid_cnt = 0;
  int busy_cnt = 0;
  logic [1:0] start_ch[$];

  ode_scheduler #(.ADDRESS_WIDTH(13), .NUM_CH(4)) dut (
    .CLK(CLK), .RST(RST), .INT(INT), .PROCESS(PROCESS),
    .ABORT(ABORT), .MODE(MODE), .CH_MASK(CH_MASK),
    .DONE(DONE), .BUSY(BUSY), .CH_DONE(CH_DONE),
    .ACTIVE_CH(ACTIVE_CH), .PASS_CNT(PASS_CNT),
    .ENG_START(ENG_START), .ENG_DONE(ENG_DONE),
    .ENG_INTERP_EN(ENG_INTERP_EN),
    .ENG_INTERP_DONE(ENG_INTERP_DONE),
    .Interpolate_Enable(Interpolate_Enable),
    .Interpolate_DONE(Interpolate_DONE),
    .ENG_ADD_RD1(ENG_ADD_RD1), .ENG_ADD_RD2(ENG_ADD_RD2),
    .ENG_ADD_WR(ENG_ADD_WR), .ENG_WR_EN(ENG_WR_EN),
    .RAM_ADD_RD1(RAM_ADD_RD1), .RAM_ADD_RD2(RAM_ADD_RD2),
    .RAM_ADD_WR(RAM_ADD_WR), .RAM_ENABLE_WR(RAM_ENABLE_WR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ENG_START) begin
      start_cnt++;
      start_ch.push_back(ACTIVE_CH);
    end
    if (ENG_INTERP_DONE) eid_cnt++;
    if (BUSY) busy_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_int();
    INT = 1'b1;
    tick();
    INT = 1'b0;
  endtask

  // Engine responds with ENG_DONE five cycles after ENG_START
  task automatic run_channel();
    tick();
    repeat (3) tick();
    ENG_DONE = 1'b1;
    tick();
    ENG_DONE = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    tick();
    checks++;
    if ({DONE, BUSY, ENG_START, ENG_INTERP_DONE, Interpolate_Enable} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
        {DONE, BUSY, ENG_START, ENG_INTERP_DONE, Interpolate_Enable});
    end
    checks++;
    if ({CH_DONE, ACTIVE_CH, PASS_CNT} !== 22'd0) begin
      failures++;
      $display("FAIL reset_state ch_done=%b active=%0d pass=%0d",
        CH_DONE, ACTIVE_CH, PASS_CNT);
    end
  endtask

  task automatic test_int_ignored();
    int s0;
    s0 = start_cnt;
    PROCESS = 1'b0;
    CH_MASK = 4'b0001;
    pulse_int();
    tick();
    checks++;
    if (BUSY !== 1'b0 || start_cnt != s0) begin
      failures++;
      $display("FAIL int_no_process busy=%b starts=%0d exp=0,0",
        BUSY, start_cnt - s0);
    end
    PROCESS = 1'b1;
  endtask

  task automatic test_two_channel();
    int s0;
    s0 = start_cnt;
    MODE = 1'b0;
    CH_MASK = 4'b1010;
    pulse_int();
    CH_MASK = 4'b0101;
    checks++;
    if (ENG_START !== 1'b1 || ACTIVE_CH !== 2'd1 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL first_start start=%b ch=%0d busy=%b exp=1,1,1",
        ENG_START, ACTIVE_CH, BUSY);
    end
    run_channel();
    checks++;
    if (ENG_START !== 1'b1 || ACTIVE_CH !== 2'd3 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL second_start start=%b ch=%0d done=%b exp=1,3,0",
        ENG_START, ACTIVE_CH, DONE);
    end
    run_channel();
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || CH_DONE !== 4'b1010) begin
      failures++;
      $display("FAIL pass_done done=%b busy=%b ch_done=%b exp=1,0,1010",
        DONE, BUSY, CH_DONE);
    end
    checks++;
    if (PASS_CNT !== 16'd1) begin
      failures++;
      $display("FAIL pass_cnt1 got=%0d exp=1", PASS_CNT);
    end
    checks++;
    if (start_cnt - s0 != 2 || start_ch[s0] !== 2'd1 ||
        start_ch[s0+1] !== 2'd3) begin
      failures++;
      $display("FAIL start_seq count=%0d exp=2 chans 1,3",
        start_cnt - s0);
    end
    tick();
    checks++;
    if (DONE !== 1'b1) begin
      failures++;
      $display("FAIL done_held got=%b exp=1", DONE);
    end
  endtask

  task automatic test_interp_pending();
    int e0;
    e0 = eid_cnt;
    CH_MASK = 4'b0011;
    pulse_int();
    checks++;
    if (DONE !== 1'b0 || ENG_START !== 1'b1 || ACTIVE_CH !== 2'd0) begin
      failures++;
      $display("FAIL ip_start done=%b start=%b ch=%0d exp=0,1,0",
        DONE, ENG_START, ACTIVE_CH);
    end
    tick();
    ENG_INTERP_EN = 1'b1;
    ENG_DONE = 1'b1;
    tick();
    ENG_INTERP_EN = 1'b0;
    ENG_DONE = 1'b0;
    checks++;
    if (Interpolate_Enable !== 1'b1 || CH_DONE !== 4'b0000) begin
      failures++;
      $display("FAIL ip_enter ie=%b ch_done=%b exp=1,0000",
        Interpolate_Enable, CH_DONE);
    end
    tick();
    tick();
    checks++;
    if (Interpolate_Enable !== 1'b1 || ENG_INTERP_DONE !== 1'b0) begin
      failures++;
      $display("FAIL ip_hold ie=%b eid=%b exp=1,0",
        Interpolate_Enable, ENG_INTERP_DONE);
    end
    Interpolate_DONE = 1'b1;
    tick();
    Interpolate_DONE = 1'b0;
    checks++;
    if (ENG_INTERP_DONE !== 1'b1 || Interpolate_Enable !== 1'b0 ||
        CH_DONE !== 4'b0001) begin
      failures++;
      $display("FAIL ip_ack eid=%b ie=%b ch_done=%b exp=1,0,0001",
        ENG_INTERP_DONE, Interpolate_Enable, CH_DONE);
    end
    tick();
    checks++;
    if (ENG_INTERP_DONE !== 1'b0 || ENG_START !== 1'b1 ||
        ACTIVE_CH !== 2'd1) begin
      failures++;
      $display("FAIL ip_next eid=%b start=%b ch=%0d exp=0,1,1",
        ENG_INTERP_DONE, ENG_START, ACTIVE_CH);
    end
    run_channel();
    checks++;
    if (eid_cnt - e0 != 1 || DONE !== 1'b1 || CH_DONE !== 4'b0011 ||
        PASS_CNT !== 16'd2) begin
      failures++;
      $display("FAIL ip_end acks=%0d done=%b ch_done=%b pass=%0d exp=1,1,0011,2",
        eid_cnt - e0, DONE, CH_DONE, PASS_CNT);
    end
  endtask

  task automatic test_continuous();
    int s0;
    s0 = start_cnt;
    MODE = 1'b1;
    CH_MASK = 4'b0001;
    pulse_int();
    run_channel();
    checks++;
    if (ENG_START !== 1'b1 || PASS_CNT !== 16'd3 || CH_DONE !== 4'b0000) begin
      failures++;
      $display("FAIL cont_wrap start=%b pass=%0d ch_done=%b exp=1,3,0000",
        ENG_START, PASS_CNT, CH_DONE);
    end
    run_channel();
    run_channel();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checks++;
    if (PASS_CNT !== 16'd5 || DONE !== 1'b0 || BUSY !== 1'b0 ||
        ENG_START !== 1'b0) begin
      failures++;
      $display("FAIL abort pass=%0d done=%b busy=%b start=%b exp=5,0,0,0",
        PASS_CNT, DONE, BUSY, ENG_START);
    end
    repeat (6) tick();
    checks++;
    if (start_cnt - s0 != 4 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet starts=%0d busy=%b exp=4,0",
        start_cnt - s0, BUSY);
    end
    MODE = 1'b0;
  endtask

  task automatic test_zero_mask();
    int s0, b0;
    s0 = start_cnt;
    b0 = busy_cnt;
    CH_MASK = 4'b0000;
    pulse_int();
    checks++;
    if (DONE !== 1'b1 || PASS_CNT !== 16'd5) begin
      failures++;
      $display("FAIL zero_done done=%b pass=%0d exp=1,5", DONE, PASS_CNT);
    end
    repeat (3) tick();
    checks++;
    if (start_cnt != s0 || busy_cnt != b0 || DONE !== 1'b1) begin
      failures++;
      $display("FAIL zero_quiet starts=%0d busy=%0d done=%b exp=0,0,1",
        start_cnt - s0, busy_cnt - b0, DONE);
    end
  endtask

  task automatic test_addr();
    CH_MASK = 4'b0100;
    ENG_ADD_WR = 11'h123;
    ENG_ADD_RD1 = 11'h7FF;
    ENG_ADD_RD2 = 11'h001;
    ENG_WR_EN = 1'b1;
    pulse_int();
    checks++;
    if (RAM_ENABLE_WR !== 1'b0 || ACTIVE_CH !== 2'd2) begin
      failures++;
      $display("FAIL addr_start we=%b ch=%0d exp=0,2",
        RAM_ENABLE_WR, ACTIVE_CH);
    end
    tick();
    checks++;
    if (RAM_ADD_WR !== 13'h1123 || RAM_ENABLE_WR !== 1'b1) begin
      failures++;
      $display("FAIL addr_run wr=%h we=%b exp=1123,1",
        RAM_ADD_WR, RAM_ENABLE_WR);
    end
    checks++;
    if (RAM_ADD_RD1 !== 13'h17FF || RAM_ADD_RD2 !== 13'h1001) begin
      failures++;
      $display("FAIL addr_rd rd1=%h rd2=%h exp=17ff,1001",
        RAM_ADD_RD1, RAM_ADD_RD2);
    end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checks++;
    if (RAM_ENABLE_WR !== 1'b0 || RAM_ADD_WR !== 13'h1123) begin
      failures++;
      $display("FAIL addr_idle we=%b wr=%h exp=0,1123",
        RAM_ENABLE_WR, RAM_ADD_WR);
    end
    ENG_WR_EN = 1'b0;
  endtask

  task automatic test_reset_in_interp();
    CH_MASK = 4'b0100;
    pulse_int();
    tick();
    ENG_INTERP_EN = 1'b1;
    tick();
    ENG_INTERP_EN = 1'b0;
    checks++;
    if (Interpolate_Enable !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre ie=%b exp=1", Interpolate_Enable);
    end
    RST = 1'b1;
    ABORT = 1'b1;
    Interpolate_DONE = 1'b1;
    tick();
    RST = 1'b0;
    ABORT = 1'b0;
    Interpolate_DONE = 1'b0;
    checks++;
    if ({DONE, BUSY, ENG_START, ENG_INTERP_DONE, Interpolate_Enable} !== 5'b0 ||
        {CH_DONE, ACTIVE_CH, PASS_CNT} !== 22'd0) begin
      failures++;
      $display("FAIL rst_interp flags=%b ch_done=%b ch=%0d pass=%0d exp=0",
        {DONE, BUSY, ENG_START, ENG_INTERP_DONE, Interpolate_Enable},
        CH_DONE, ACTIVE_CH, PASS_CNT);
    end
    CH_MASK = 4'b1000;
    pulse_int();
    checks++;
    if (ENG_START !== 1'b1 || ACTIVE_CH !== 2'd3) begin
      failures++;
      $display("FAIL rst_restart start=%b ch=%0d exp=1,3",
        ENG_START, ACTIVE_CH);
    end
  endtask

  initial begin
    test_reset();
    test_int_ignored();
    test_two_channel();
    test_interp_pending();
    test_continuous();
    test_zero_mask();
    test_addr();
    test_reset_in_interp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
